// File: rtl/cache_pkg.sv
// Shared defaults, width typedefs and the refill FSM state encoding for the
// cache refill controller.
package cache_pkg;

    localparam int SET_SIZE_DEF   = 4;
    localparam int GROUP_NUM_DEF  = 128;
    localparam int LINE_WORDS_DEF = 8;

    typedef logic [$clog2(SET_SIZE_DEF)-1:0]   way_t;
    typedef logic [$clog2(GROUP_NUM_DEF)-1:0]  index_t;
    typedef logic [$clog2(LINE_WORDS_DEF)-1:0] ofs_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REQ,
        RECV,
        DONE
    } refill_state_t;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Miss refill controller: victim lookup, burst read, line write-back into the
// data RAM and PLRU update. CACHE_REFILL_EARLY_RESTART_EN forwards the missed word on its beat.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int SET_SIZE    = SET_SIZE_DEF,
    parameter int GROUP_NUM   = GROUP_NUM_DEF,
    parameter int LINE_WORDS  = LINE_WORDS_DEF,
    parameter int WAY_WIDTH   = $clog2(SET_SIZE),
    parameter int INDEX_WIDTH = $clog2(GROUP_NUM),
    parameter int OFS_WIDTH   = $clog2(LINE_WORDS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   miss_valid,
    output logic                   miss_ready,
    input  logic [31:0]            miss_addr,
    output logic [INDEX_WIDTH-1:0] plru_index,
    input  logic [WAY_WIDTH-1:0]   lru_way,
    output logic                   plru_valid,
    output logic [WAY_WIDTH-1:0]   plru_way,
    output logic                   rd_req,
    output logic [31:0]            rd_addr,
    output logic [7:0]             rd_len,
    input  logic                   rd_gnt,
    input  logic                   ret_valid,
    input  logic                   ret_last,
    input  logic [31:0]            ret_data,
    output logic                   wr_en,
    output logic [WAY_WIDTH-1:0]   wr_way,
    output logic [INDEX_WIDTH-1:0] wr_index,
    output logic [OFS_WIDTH-1:0]   wr_offset,
    output logic [31:0]            wr_data,
    output logic                   resp_valid,
    output logic [31:0]            resp_data,
    output logic                   refill_done
);

    refill_state_t          state;
    logic [31:0]            addr_q;
    logic [WAY_WIDTH-1:0]   victim;
    logic [OFS_WIDTH-1:0]   cnt;
    logic [31:0]            word_q;

    logic [INDEX_WIDTH-1:0] miss_index;
    logic [INDEX_WIDTH-1:0] addr_index;
    logic [OFS_WIDTH-1:0]   req_ofs;
    logic                   beat;
    logic                   hit_beat;

    assign miss_index = miss_addr[OFS_WIDTH+2 +: INDEX_WIDTH];
    assign addr_index = addr_q[OFS_WIDTH+2 +: INDEX_WIDTH];
    assign req_ofs    = addr_q[2 +: OFS_WIDTH];

    // Return beats only count in RECV; strays in other states are dropped.
    assign beat       = (state == RECV) && ret_valid;
    assign hit_beat   = beat && (cnt == req_ofs);

    assign plru_index = (state == IDLE) ? miss_index : addr_index;

    assign wr_en      = beat;
    assign wr_way     = beat ? victim     : '0;
    assign wr_index   = beat ? addr_index : '0;
    assign wr_offset  = beat ? cnt        : '0;
    assign wr_data    = beat ? ret_data   : '0;

`ifdef CACHE_REFILL_EARLY_RESTART_EN
    assign resp_valid = hit_beat;
    assign resp_data  = hit_beat ? ret_data : word_q;
`else
    logic resp_q;
    assign resp_valid = resp_q;
    assign resp_data  = word_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            victim      <= '0;
            cnt         <= '0;
            word_q      <= '0;
            miss_ready  <= 1'b1;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            rd_len      <= '0;
            refill_done <= 1'b0;
            plru_valid  <= 1'b0;
            plru_way    <= '0;
`ifndef CACHE_REFILL_EARLY_RESTART_EN
            resp_q      <= 1'b0;
`endif
        end else begin
            refill_done <= 1'b0;
            plru_valid  <= 1'b0;
            plru_way    <= '0;
`ifndef CACHE_REFILL_EARLY_RESTART_EN
            resp_q      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (miss_valid) begin
                        addr_q     <= miss_addr;
                        miss_ready <= 1'b0;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    victim  <= lru_way;
                    rd_req  <= 1'b1;
                    rd_addr <= addr_q & ~32'(LINE_WORDS * 4 - 1);
                    rd_len  <= 8'(LINE_WORDS - 1);
                    state   <= REQ;
                end
                REQ: begin
                    if (rd_gnt) begin
                        rd_req  <= 1'b0;
                        rd_addr <= '0;
                        rd_len  <= '0;
                        cnt     <= '0;
                        state   <= RECV;
                    end
                end
                RECV: begin
                    if (ret_valid) begin
                        cnt <= cnt + 1'b1;
                        if (hit_beat)
                            word_q <= ret_data;
                        if (ret_last) begin
                            refill_done <= 1'b1;
                            plru_valid  <= 1'b1;
                            plru_way    <= victim;
`ifndef CACHE_REFILL_EARLY_RESTART_EN
                            resp_q      <= 1'b1;
`endif
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    miss_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: directed misses push expected bus,
// write, response and PLRU events; a negedge monitor pops and compares them.
module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic        miss_valid, rd_gnt, ret_valid, ret_last;
    logic [31:0] miss_addr, ret_data;
    logic [1:0]  lru_way;
    logic [0:0]  lru_way2;

    logic        miss_ready, plru_valid, rd_req, wr_en, resp_valid, refill_done;
    logic [6:0]  plru_index, wr_index;
    logic [1:0]  plru_way, wr_way;
    logic [31:0] rd_addr, wr_data, resp_data;
    logic [7:0]  rd_len;
    logic [2:0]  wr_offset;

    logic        miss_ready2, plru_valid2, rd_req2, wr_en2, resp_valid2, refill_done2;
    logic [6:0]  plru_index2, wr_index2;
    logic [0:0]  plru_way2, wr_way2;
    logic [31:0] rd_addr2, wr_data2, resp_data2;
    logic [7:0]  rd_len2;
    logic [2:0]  wr_offset2;

    cache_refill_ctrl u_dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .plru_index(plru_index), .lru_way(lru_way),
        .plru_valid(plru_valid), .plru_way(plru_way),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_en(wr_en), .wr_way(wr_way), .wr_index(wr_index),
        .wr_offset(wr_offset), .wr_data(wr_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .refill_done(refill_done)
    );

    cache_refill_ctrl #(.SET_SIZE(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_ready(miss_ready2), .miss_addr(miss_addr),
        .plru_index(plru_index2), .lru_way(lru_way2),
        .plru_valid(plru_valid2), .plru_way(plru_way2),
        .rd_req(rd_req2), .rd_addr(rd_addr2), .rd_len(rd_len2), .rd_gnt(rd_gnt),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_en(wr_en2), .wr_way(wr_way2), .wr_index(wr_index2),
        .wr_offset(wr_offset2), .wr_data(wr_data2),
        .resp_valid(resp_valid2), .resp_data(resp_data2), .refill_done(refill_done2)
    );

    typedef struct {
        logic [1:0]  way;
        logic [6:0]  idx;
        logic [2:0]  ofs;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_resp[$];
    logic [1:0]  exp_done[$];
    logic [31:0] exp_rd[$];
    wr_t         w;
    int          tests = 0;
    int          fails = 0;
    int          w2_beats = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_wr.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
            else begin
                w = exp_wr.pop_front();
                check("wr_way", 32'(wr_way), 32'(w.way));
                check("wr_index", 32'(wr_index), 32'(w.idx));
                check("wr_offset", 32'(wr_offset), 32'(w.ofs));
                check("wr_data", wr_data, w.data);
            end
        end
        if (resp_valid) begin
            if (exp_resp.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
            else check("resp_data", resp_data, exp_resp.pop_front());
`ifdef CACHE_REFILL_EARLY_RESTART_EN
            check("resp_with_beat", 32'(wr_en), 32'd1);
            check("resp_not_in_done", 32'(refill_done), 32'd0);
`else
            check("resp_in_done", 32'(refill_done), 32'd1);
`endif
        end
        if (plru_valid) begin
            if (exp_done.size() == 0) check("plru_unexpected", 32'd1, 32'd0);
            else check("plru_way", 32'(plru_way), 32'(exp_done.pop_front()));
            check("done_with_plru", 32'(refill_done), 32'd1);
        end else if (refill_done) begin
            check("done_without_plru", 32'd0, 32'd1);
        end
        if (rd_req && rd_gnt) begin
            if (exp_rd.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
            else check("rd_addr", rd_addr, exp_rd.pop_front());
            check("rd_len", 32'(rd_len), 32'd7);
        end
        if (wr_en2) begin
            w2_beats++;
            check("w2_way", 32'(wr_way2), 32'd1);
        end
        if (plru_valid2) check("p2_way", 32'(plru_way2), 32'd1);
    end

    task automatic refill(input logic [31:0] addr, input logic [1:0] lru, input int gnt_wait,
                          input logic [31:0] base, input int n_beats, input bit stray,
                          input bit hold, input logic [31:0] next_addr);
        logic [6:0] idx;
        logic [2:0] ofs;
        idx = addr[11:5];
        ofs = addr[4:2];
        exp_rd.push_back(addr & ~32'h1F);
        for (int i = 0; i < n_beats; i++)
            exp_wr.push_back('{way: lru, idx: idx, ofs: 3'(i), data: base + 32'(i)});
`ifdef CACHE_REFILL_EARLY_RESTART_EN
        if (int'(ofs) < n_beats) exp_resp.push_back(base + 32'(ofs));
`else
        if (n_beats == 8) exp_resp.push_back(base + 32'(ofs));
`endif
        if (n_beats == 8) exp_done.push_back(lru);

        miss_valid = 1'b1;
        miss_addr  = addr;
        lru_way    = lru;
        @(posedge clk); #1;
        check("miss_ready_busy", 32'(miss_ready), 32'd0);
        check("plru_index", 32'(plru_index), 32'(idx));
        if (hold) miss_addr = next_addr;
        else miss_valid = 1'b0;
        @(posedge clk); #1;
        check("rd_req_in_req", 32'(rd_req), 32'd1);
        for (int i = 0; i < gnt_wait; i++) begin
            if (stray && i == 0) begin
                ret_valid = 1'b1;
                ret_last  = 1'b1;
                ret_data  = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            ret_valid = 1'b0;
            ret_last  = 1'b0;
        end
        rd_gnt = 1'b1;
        @(posedge clk); #1;
        rd_gnt = 1'b0;
        check("rd_req_dropped", 32'(rd_req), 32'd0);
        for (int i = 0; i < n_beats; i++) begin
            ret_valid = 1'b1;
            ret_data  = base + 32'(i);
            ret_last  = (i == 7);
            @(posedge clk); #1;
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        if (n_beats == 8) begin
            check("done_pulse", 32'(refill_done), 32'd1);
            check("miss_ready_in_done", 32'(miss_ready), 32'd0);
            @(posedge clk); #1;
            check("miss_ready_idle", 32'(miss_ready), 32'd1);
            check("done_cleared", 32'(refill_done), 32'd0);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_miss_ready"}, 32'(miss_ready), 32'd1);
        check({tag, "_rd_req"}, 32'(rd_req), 32'd0);
        check({tag, "_rd_addr"}, rd_addr, 32'd0);
        check({tag, "_rd_len"}, 32'(rd_len), 32'd0);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_wr_data"}, wr_data, 32'd0);
        check({tag, "_plru_valid"}, 32'(plru_valid), 32'd0);
        check({tag, "_plru_way"}, 32'(plru_way), 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_data"}, resp_data, 32'd0);
        check({tag, "_refill_done"}, 32'(refill_done), 32'd0);
    endtask

    initial begin
        miss_valid = 1'b0; miss_addr = '0; lru_way = '0; lru_way2 = 1'b1;
        rd_gnt = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        check("rst_plru_index", 32'(plru_index), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Reference miss: index 0x11, offset 5, grant after 2 cycles
        refill(32'h0000_1234, 2'd2, 2, 32'hA0, 8, 1'b0, 1'b0, 32'h0);

        // Back-to-back: second miss held on the port during the first refill
        refill(32'h0000_2468, 2'd1, 0, 32'hB0, 8, 1'b0, 1'b1, 32'h0000_0FFC);
        refill(32'h0000_0FFC, 2'd3, 1, 32'hC0, 8, 1'b0, 1'b0, 32'h0);

        // Stray return beat while waiting for the grant
        refill(32'h0000_0040, 2'd0, 3, 32'hD0, 8, 1'b1, 1'b0, 32'h0);

        // Reset after three beats, then a clean refill
        refill(32'h0000_1234, 2'd2, 1, 32'hE0, 3, 1'b0, 1'b0, 32'h0);
        ret_valid = 1'b1;
        ret_data  = 32'h55;
        reset     = 1'b0;
        #1;
        reset_checks("midrst");
        @(posedge clk); #1;
        ret_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        refill(32'h8000_0020, 2'd3, 0, 32'hF0, 8, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        check("exp_wr_left", 32'(exp_wr.size()), 32'd0);
        check("exp_resp_left", 32'(exp_resp.size()), 32'd0);
        check("exp_done_left", 32'(exp_done.size()), 32'd0);
        check("exp_rd_left", 32'(exp_rd.size()), 32'd0);
        check("w2_beat_count", 32'(w2_beats), 32'd43);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter SET_SIZE, default 4, ways per set; the block SHALL support 2 and 4.
REQ-002 Parameter GROUP_NUM, default 128, sets per cache.
REQ-003 Parameter LINE_WORDS, default 8, 32-bit words per line, power of two.
REQ-004 Derived widths SHALL be WAY_WIDTH=$clog2(SET_SIZE), INDEX_WIDTH=$clog2(GROUP_NUM), OFS_WIDTH=$clog2(LINE_WORDS).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 miss_valid  in  1 / miss_ready  out  1 / miss_addr  in  32: miss request handshake from the M1 stage.
REQ-008 plru_index  out  INDEX_WIDTH / lru_way  in  WAY_WIDTH: victim lookup into the PLRU, combinational return.
REQ-009 plru_valid  out  1 / plru_way  out  WAY_WIDTH: PLRU update carrying the refilled way.
REQ-010 rd_req  out  1 / rd_addr  out  32 / rd_len  out  8 / rd_gnt  in  1: burst read request to the bus.
REQ-011 ret_valid  in  1 / ret_last  in  1 / ret_data  in  32: burst return beats.
REQ-012 wr_en  out  1 / wr_way  out  WAY_WIDTH / wr_index  out  INDEX_WIDTH / wr_offset  out  OFS_WIDTH / wr_data  out  32: data-RAM write port.
REQ-013 resp_valid  out  1 / resp_data  out  32 / refill_done  out  1: requested word and refill completion to the pipeline.

Function
REQ-014 The FSM SHALL have the states IDLE, LOOKUP, REQ, RECV and DONE.
REQ-015 miss_ready SHALL be 1 only in IDLE; miss_valid&&miss_ready SHALL latch miss_addr and move to LOOKUP.
REQ-016 Address split: offset = addr[OFS_WIDTH+1:2], index = addr[OFS_WIDTH+2+INDEX_WIDTH-1:OFS_WIDTH+2].
REQ-017 plru_index SHALL equal the latched index in every non-IDLE state and miss_addr's index in IDLE.
REQ-018 LOOKUP SHALL last exactly one cycle, register lru_way as the victim, then move to REQ.
REQ-019 In REQ: rd_req=1, rd_addr = latched address with bits [OFS_WIDTH+1:0] cleared, rd_len = LINE_WORDS-1; rd_gnt moves to RECV.
REQ-020 The beat counter SHALL reset to 0 on entering RECV and increment per ret_valid, wrapping modulo LINE_WORDS.
REQ-021 Each ret_valid in RECV SHALL produce the same-cycle output wr_en=1, wr_way=victim, wr_index=latched index, wr_offset=counter, wr_data=ret_data.
REQ-022 ret_valid&&ret_last in RECV SHALL move to DONE; no other condition ends RECV.
REQ-023 ret_valid outside RECV SHALL be ignored, with no write and no state change.
REQ-024 The beat whose counter equals the requested offset SHALL be captured into resp_data.
REQ-025 DONE SHALL last one cycle with refill_done=1, plru_valid=1 and plru_way=victim, then return to IDLE.
REQ-026 Miss-to-IDLE latency SHALL be 3 + grant wait + number of beats, in cycles.

Reset
REQ-027 While reset=0: state IDLE, counter 0, all outputs 0 except miss_ready=1.
REQ-028 Reset asserted mid-refill SHALL abandon the line with no further wr_en and no PLRU update; data already written remains.

Configuration
REQ-029 Macro CACHE_REFILL_EARLY_RESTART_EN defined: resp_valid SHALL pulse for one cycle in the RECV cycle of the requested beat, with resp_data=ret_data that cycle; DONE SHALL NOT assert resp_valid.
REQ-030 Macro undefined: resp_valid SHALL pulse only in DONE, with resp_data holding the captured word.

Structure
REQ-031 cache_pkg SHALL hold the SET_SIZE/GROUP_NUM/LINE_WORDS defaults, the derived width typedefs (index_t, way_t, ofs_t) and the state enum refill_state_t.
REQ-032 No sub-module; the parent instantiates PLRU and wires plru_index/lru_way/plru_valid/plru_way to it.

Verification
REQ-033 Reset, then miss_addr=0x0000_1234 with lru_way=2 and rd_gnt after 2 cycles -> rd_addr=0x0000_1220, rd_len=7, eight wr_en beats on way 2, index 0x11, offsets 0..7.
REQ-034 Same miss with data beats 0xA0..0xA7 -> resp_data=0xA5 (offset 5); resp_valid on beat 6 with the macro, in DONE without it.
REQ-035 miss_valid held during a refill -> miss_ready=0 until the cycle after DONE, then the second miss is accepted.
REQ-036 ret_valid pulsed in REQ before rd_gnt -> no wr_en, and the counter is still 0 at the first RECV beat.
REQ-037 reset dropped after beat 3 -> all outputs 0 next, no plru_valid, and a new miss then completes normally.
REQ-038 SET_SIZE=2 build, lru_way=1 -> all writes on way 1, plru_way=1 in DONE.
